// File: rtl/vga_write_ctrl.sv
// Frame-memory write arbiter: CPU and keyboard round-robin, plus a full-screen clear sequencer.
// Latency: a grant decided at a clock edge drives ACK and the write port in the same registered cycle.
// Backpressure: requesters hold REQ until ACK; the clear stalls both requesters for MEM_SIZE cycles.
module vga_write_ctrl #(
  parameter int MEM_SIZE = 20000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_REQ,
  input  logic [15:0] CPU_ADDR,
  input  logic [15:0] CPU_DATA,
  output logic        CPU_ACK,
  input  logic        KB_REQ,
  input  logic [15:0] KB_DATA,
  output logic        KB_ACK,
  input  logic        CLR_REQ,
  output logic        BUSY,
  output logic [15:0] KB_CURSOR,
  output logic        ADDR_ERR,
  output logic        MW_VGA_ON,
  output logic [15:0] WADDR_VGA,
  output logic [15:0] DATA_IN_VGA
);

  // 17-bit size so a full 64K-word memory still compares correctly.
  localparam logic [16:0] MEM_SIZE_W = 17'(MEM_SIZE);
  localparam logic [15:0] LAST_ADDR  = 16'(MEM_SIZE - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        kb_ack_q, kb_ack_d;
  logic        mw_q, mw_d;
  logic [15:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] kb_cursor_q, kb_cursor_d;
  logic        addr_err_q, addr_err_d;
  // 1 = keyboard was granted most recently, so the CPU wins the next tie.
  logic        kb_last_q, kb_last_d;

  logic        cpu_elig;
  logic        kb_elig;
  logic        cpu_addr_ok;

  // A requester's REQ is still high in the cycle right after its ACK; mask it there.
  assign cpu_elig    = CPU_REQ && !cpu_ack_q;
  assign kb_elig     = KB_REQ && !kb_ack_q;
  assign cpu_addr_ok = ({1'b0, CPU_ADDR} < MEM_SIZE_W);

  // Next-state: clear sequencing in CLEAR, priority clear then round-robin grant in IDLE.
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    cpu_ack_d   = 1'b0;
    kb_ack_d    = 1'b0;
    mw_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    kb_cursor_d = kb_cursor_q;
    addr_err_d  = addr_err_q;
    kb_last_d   = kb_last_q;

    case (state_q)
      ST_IDLE: begin
        if (CLR_REQ) begin
          // Address 0 is written in the entry cycle so the clear spans exactly MEM_SIZE cycles.
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
          mw_d    = 1'b1;
          waddr_d = 16'h0000;
          wdata_d = 16'h0000;
        end else if (cpu_elig && (!kb_elig || kb_last_q)) begin
          cpu_ack_d = 1'b1;
          kb_last_d = 1'b0;
          if (cpu_addr_ok) begin
            mw_d    = 1'b1;
            waddr_d = CPU_ADDR;
            wdata_d = CPU_DATA;
          end else begin
            // Out-of-range write is acknowledged but dropped; the address port keeps its old value.
            addr_err_d = 1'b1;
          end
        end else if (kb_elig) begin
          kb_ack_d    = 1'b1;
          kb_last_d   = 1'b1;
          mw_d        = 1'b1;
          waddr_d     = kb_cursor_q;
          wdata_d     = KB_DATA;
          kb_cursor_d = (kb_cursor_q == LAST_ADDR) ? 16'h0000 : kb_cursor_q + 16'd1;
        end
      end

      ST_CLEAR: begin
        // The write address register doubles as the clear counter.
        if (waddr_q == LAST_ADDR) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          kb_cursor_d = 16'h0000;
        end else begin
          mw_d    = 1'b1;
          waddr_d = waddr_q + 16'd1;
          wdata_d = 16'h0000;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any clear in progress.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      cpu_ack_q   <= 1'b0;
      kb_ack_q    <= 1'b0;
      mw_q        <= 1'b0;
      waddr_q     <= 16'h0000;
      wdata_q     <= 16'h0000;
      kb_cursor_q <= 16'h0000;
      addr_err_q  <= 1'b0;
      kb_last_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      cpu_ack_q   <= cpu_ack_d;
      kb_ack_q    <= kb_ack_d;
      mw_q        <= mw_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      kb_cursor_q <= kb_cursor_d;
      addr_err_q  <= addr_err_d;
      kb_last_q   <= kb_last_d;
    end
  end

  assign CPU_ACK     = cpu_ack_q;
  assign KB_ACK      = kb_ack_q;
  assign BUSY        = busy_q;
  assign KB_CURSOR   = kb_cursor_q;
  assign ADDR_ERR    = addr_err_q;
  assign MW_VGA_ON   = mw_q;
  assign WADDR_VGA   = waddr_q;
  assign DATA_IN_VGA = wdata_q;

endmodule

// File: tb/tb_vga_write_ctrl.sv
// Bench for vga_write_ctrl: directed scenarios plus randomized traffic against a memory-level model.
// Instance a uses an 8-word memory, instance b the default size.
module tb_vga_write_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance a (MEM_SIZE = 8)
  logic        a_cpu_req = 0, a_kb_req = 0, a_clr = 0;
  logic [15:0] a_cpu_addr = 0, a_cpu_data = 0, a_kb_data = 0;
  logic        a_cpu_ack, a_kb_ack, a_busy, a_err, a_mw;
  logic [15:0] a_cursor, a_waddr, a_din;

  // Instance b (default MEM_SIZE)
  logic        b_cpu_req = 0, b_kb_req = 0, b_clr = 0;
  logic [15:0] b_cpu_addr = 0, b_cpu_data = 0, b_kb_data = 0;
  logic        b_cpu_ack, b_kb_ack, b_busy, b_err, b_mw;
  logic [15:0] b_cursor, b_waddr, b_din;

  vga_write_ctrl #(.MEM_SIZE(8)) dut_a (
    .CLK(clk), .RST(rst),
    .CPU_REQ(a_cpu_req), .CPU_ADDR(a_cpu_addr), .CPU_DATA(a_cpu_data), .CPU_ACK(a_cpu_ack),
    .KB_REQ(a_kb_req), .KB_DATA(a_kb_data), .KB_ACK(a_kb_ack),
    .CLR_REQ(a_clr), .BUSY(a_busy), .KB_CURSOR(a_cursor), .ADDR_ERR(a_err),
    .MW_VGA_ON(a_mw), .WADDR_VGA(a_waddr), .DATA_IN_VGA(a_din)
  );

  vga_write_ctrl dut_b (
    .CLK(clk), .RST(rst),
    .CPU_REQ(b_cpu_req), .CPU_ADDR(b_cpu_addr), .CPU_DATA(b_cpu_data), .CPU_ACK(b_cpu_ack),
    .KB_REQ(b_kb_req), .KB_DATA(b_kb_data), .KB_ACK(b_kb_ack),
    .CLR_REQ(b_clr), .BUSY(b_busy), .KB_CURSOR(b_cursor), .ADDR_ERR(b_err),
    .MW_VGA_ON(b_mw), .WADDR_VGA(b_waddr), .DATA_IN_VGA(b_din)
  );

  // Frame memories as the real RAM would see them: captured on the falling edge.
  logic [15:0] a_mem [8];
  int          a_wr_cnt = 0;
  int          b_wr_cnt = 0;
  always @(negedge clk) begin
    if (a_mw === 1'b1) begin
      a_wr_cnt++;
      if (a_waddr < 16'd8) a_mem[a_waddr[2:0]] = a_din;
    end
    if (b_mw === 1'b1) b_wr_cnt++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ack_of(input int sel);
    case (sel)
      0:       return a_cpu_ack;
      1:       return a_kb_ack;
      default: return b_cpu_ack;
    endcase
  endfunction

  task automatic wait_ack(input int sel, input int limit, output bit got);
    got = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (ack_of(sel) === 1'b1) begin
        got = 1;
        break;
      end
    end
  endtask

  // Reference model state for the randomized phase
  logic [15:0] exp_mem [8];
  int          exp_cursor;
  logic        exp_err;
  bit          cpu_p, kb_p;
  int          cpu_wait, kb_wait;
  logic [15:0] cpu_a, cpu_d, kb_d;
  bit          got;
  int          snap, busy_n;
  logic [1:0]  rr_exp [4];

  initial begin
    // ---------------- reset values
    #2 rst = 1'b1;
    #1;
    check("rst_a_outs", {a_busy, a_cpu_ack, a_kb_ack, a_mw, a_err}, 5'b0);
    check("rst_a_regs", {a_waddr, a_din, a_cursor}, 48'h0);
    check("rst_b_outs", {b_busy, b_cpu_ack, b_kb_ack, b_mw, b_err}, 5'b0);
    check("rst_b_regs", {b_waddr, b_din, b_cursor}, 48'h0);
    step();
    step();
    rst = 1'b0;
    step();

    // ---------------- single CPU write, default size
    snap = b_wr_cnt;
    b_cpu_req = 1; b_cpu_addr = 16'd100; b_cpu_data = 16'hABCD;
    wait_ack(2, 5, got);
    check("cpu_single_ack", got, 1);
    check("cpu_single_write", {b_mw, b_kb_ack, b_waddr, b_din}, {2'b10, 16'd100, 16'hABCD});
    b_cpu_req = 0;
    step();
    check("cpu_single_after", {b_mw, b_cpu_ack}, 2'b00);
    step();
    check("cpu_single_count", b_wr_cnt - snap, 1);

    // ---------------- bad CPU address, default size
    snap = b_wr_cnt;
    b_cpu_req = 1; b_cpu_addr = 16'd20000; b_cpu_data = 16'h1234;
    wait_ack(2, 5, got);
    check("bad_addr_ack", got, 1);
    check("bad_addr_flags", {b_mw, b_err}, 2'b01);
    check("bad_addr_port_hold", {b_waddr, b_din}, {16'd100, 16'hABCD});
    b_cpu_req = 0;
    repeat (10) step();
    check("bad_addr_sticky", b_err, 1);
    check("bad_addr_no_write", b_wr_cnt - snap, 0);

    // ---------------- tie from reset: CPU, KB, CPU, KB
    rr_exp[0] = 2'b10; rr_exp[1] = 2'b01; rr_exp[2] = 2'b10; rr_exp[3] = 2'b01;
    a_cpu_req = 1; a_cpu_addr = 16'd5; a_cpu_data = 16'h1111;
    a_kb_req = 1;  a_kb_data = 16'h2222;
    check("tie_cursor0", a_cursor, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("tie_grant%0d", i), {a_cpu_ack, a_kb_ack}, rr_exp[i]);
      if (i == 1) check("tie_cursor1", {a_cursor, a_waddr}, {16'd1, 16'd0});
      if (i == 3) check("tie_cursor2", {a_cursor, a_waddr}, {16'd2, 16'd1});
    end
    a_cpu_req = 0; a_kb_req = 0;
    step();

    // ---------------- clear with keyboard pending
    a_clr = 1; a_kb_req = 1; a_kb_data = 16'h3333;
    busy_n = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      a_clr = 0;
      if (a_busy === 1'b1) begin
        check("clr_write", {a_mw, a_kb_ack, a_cpu_ack, a_waddr, a_din},
              {3'b100, 16'(busy_n), 16'h0000});
        busy_n++;
      end else if (a_kb_ack === 1'b1) begin
        got = 1;
        break;
      end
    end
    check("clr_busy_len", busy_n, 8);
    check("clr_kb_ack", got, 1);
    check("clr_kb_write", {a_mw, a_waddr, a_din, a_cursor}, {1'b1, 16'd0, 16'h3333, 16'd1});
    a_kb_req = 0;
    step();

    // ---------------- reset in the middle of a clear
    a_clr = 1;
    step();
    a_clr = 0;
    step();
    step();
    check("mid_clr_busy", {a_busy, a_waddr}, {1'b1, 16'd2});
    rst = 1'b1;
    #1;
    check("mid_clr_rst", {a_busy, a_mw, a_cursor}, {2'b00, 16'd0});
    snap = a_wr_cnt;
    step();
    rst = 1'b0;
    repeat (12) step();
    check("mid_clr_no_resume", {a_busy, 32'(a_wr_cnt - snap)}, 33'd0);

    // ---------------- keyboard cursor wrap: 9 writes
    a_kb_req = 1; a_kb_data = 16'hC000;
    for (int i = 0; i < 9; i++) begin
      wait_ack(1, 4, got);
      check($sformatf("wrap_ack%0d", i), got, 1);
      check($sformatf("wrap_write%0d", i), {a_mw, a_waddr, a_din},
            {1'b1, 16'(i % 8), 16'hC000 + 16'(i)});
      a_kb_data = 16'hC000 + 16'(i + 1);
    end
    a_kb_req = 0;
    step();
    check("wrap_cursor_end", a_cursor, 1);

    // ---------------- randomized traffic against a memory model
    a_clr = 1;
    step();
    a_clr = 0;
    for (int i = 0; i < 20 && a_busy === 1'b1; i++) step();
    check("rand_clear_done", a_busy, 0);
    for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0000;
    exp_cursor = 0; exp_err = 1'b0;
    cpu_p = 0; kb_p = 0; cpu_wait = 0; kb_wait = 0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      step();
      if (cpu_p) cpu_wait++;
      if (kb_p) kb_wait++;
      if (a_cpu_ack === 1'b1 && a_kb_ack === 1'b1) check("rand_one_grant", 2'b11, 2'b01);
      if (a_cpu_ack === 1'b1) begin
        check("rand_cpu_pending", cpu_p, 1);
        check("rand_cpu_latency", cpu_wait <= 4, 1);
        if (cpu_a < 16'd8) begin
          check("rand_cpu_write", {a_mw, a_waddr, a_din}, {1'b1, cpu_a, cpu_d});
          exp_mem[cpu_a[2:0]] = cpu_d;
        end else begin
          check("rand_cpu_bad", a_mw, 0);
          exp_err = 1'b1;
        end
        cpu_p = 0;
      end else if (a_kb_ack === 1'b1) begin
        check("rand_kb_pending", kb_p, 1);
        check("rand_kb_latency", kb_wait <= 4, 1);
        check("rand_kb_write", {a_mw, a_waddr, a_din}, {1'b1, 16'(exp_cursor), kb_d});
        exp_mem[exp_cursor] = kb_d;
        exp_cursor = (exp_cursor + 1) % 8;
        kb_p = 0;
      end else begin
        check("rand_idle_mw", a_mw, 0);
      end
      check("rand_cursor", a_cursor, 16'(exp_cursor));
      check("rand_err", a_err, exp_err);
      if (cyc < 400) begin
        if (!cpu_p && $urandom_range(0, 2) != 0) begin
          cpu_p = 1; cpu_wait = 0;
          cpu_a = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(8, 15)) : 16'($urandom_range(0, 7));
          cpu_d = 16'($urandom);
        end
        if (!kb_p && $urandom_range(0, 2) != 0) begin
          kb_p = 1; kb_wait = 0;
          kb_d = 16'($urandom);
        end
      end else if (!cpu_p && !kb_p) begin
        break;
      end
      a_cpu_req = cpu_p; a_cpu_addr = cpu_a; a_cpu_data = cpu_d;
      a_kb_req = kb_p;   a_kb_data = kb_d;
    end
    a_cpu_req = 0; a_kb_req = 0;
    check("rand_drained", {cpu_p, kb_p}, 2'b00);
    step();
    step();
    for (int i = 0; i < 8; i++) check($sformatf("rand_mem%0d", i), a_mem[i], exp_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_write_ctrl.md
VGA_WRITE_CTRL -- requirements
Module: vga_write_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 20000, meaning the number of 16-bit words in the VGA frame memory.
REQ-002 SHALL have port CLK, input, 1 bit, the single clock; all state changes on posedge CLK.
REQ-003 SHALL have port RST, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port CPU_REQ, input, 1 bit, CPU write request.
REQ-005 SHALL have port CPU_ADDR, input, 16 bits, CPU write address.
REQ-006 SHALL have port CPU_DATA, input, 16 bits, CPU write data.
REQ-007 SHALL have port CPU_ACK, output, 1 bit, one-cycle grant pulse to the CPU.
REQ-008 SHALL have port KB_REQ, input, 1 bit, keyboard character-write request.
REQ-009 SHALL have port KB_DATA, input, 16 bits, keyboard character word.
REQ-010 SHALL have port KB_ACK, output, 1 bit, one-cycle grant pulse to the keyboard.
REQ-011 SHALL have port CLR_REQ, input, 1 bit, screen-clear request.
REQ-012 SHALL have port BUSY, output, 1 bit, high while a clear is in progress.
REQ-013 SHALL have port KB_CURSOR, output, 16 bits, next keyboard write address.
REQ-014 SHALL have port ADDR_ERR, output, 1 bit, sticky flag for an out-of-range CPU address.
REQ-015 SHALL have port MW_VGA_ON, output, 1 bit, frame-memory write enable.
REQ-016 SHALL have port WADDR_VGA, output, 16 bits, frame-memory write address.
REQ-017 SHALL have port DATA_IN_VGA, output, 16 bits, frame-memory write data.

Function
REQ-018 SHALL register all outputs; a grant decided at posedge k drives ACK, MW_VGA_ON, WADDR_VGA and DATA_IN_VGA during cycle k; the memory captures the write on the following negedge.
REQ-019 SHALL implement two states: IDLE and CLEAR.
REQ-020 In IDLE, CLR_REQ high SHALL take priority over CPU and keyboard, enter CLEAR and issue no grant that cycle.
REQ-021 In CLEAR, the block SHALL write 16'h0000 to addresses 0..MEM_SIZE-1, one address per cycle in ascending order, with MW_VGA_ON high.
REQ-022 After writing MEM_SIZE-1, the block SHALL return to IDLE and set KB_CURSOR to 0; a clear lasts exactly MEM_SIZE cycles.
REQ-023 BUSY SHALL be high on every cycle in which the block is in CLEAR.
REQ-024 During CLEAR, CLR_REQ SHALL be ignored; CPU_REQ and KB_REQ SHALL receive no ACK and SHALL remain pending.
REQ-025 In IDLE without CLR_REQ, the block SHALL grant at most one requester per cycle.
REQ-026 If both requesters are eligible, the grant SHALL go to the one not granted most recently (round-robin).
REQ-027 The round-robin pointer SHALL reset to "keyboard last", so the CPU wins the first tie.
REQ-028 Each requester SHALL hold REQ, address and data stable until it sees ACK.
REQ-029 A requester SHALL NOT be granted in the cycle immediately after its own ACK, which masks the stale REQ; its maximum rate is one write per two cycles.
REQ-030 A CPU grant SHALL write CPU_DATA to CPU_ADDR.
REQ-031 If CPU_ADDR >= MEM_SIZE, the block SHALL still pulse CPU_ACK, SHALL hold MW_VGA_ON low, and SHALL set ADDR_ERR.
REQ-032 ADDR_ERR SHALL stay set until reset.
REQ-033 A keyboard grant SHALL write KB_DATA to KB_CURSOR.
REQ-034 After each keyboard write, KB_CURSOR SHALL increment by 1, wrapping from MEM_SIZE-1 to 0.
REQ-035 When no write is issued, MW_VGA_ON SHALL be 0; WADDR_VGA and DATA_IN_VGA SHALL hold their last values.

Reset
REQ-036 RST high SHALL immediately force the following values: state IDLE; BUSY, CPU_ACK, KB_ACK, MW_VGA_ON and ADDR_ERR = 0; WADDR_VGA, DATA_IN_VGA and KB_CURSOR = 0; round-robin pointer = keyboard-last.
REQ-037 RST asserted mid-clear SHALL abort the clear with no further writes; the clear SHALL NOT resume after RST deasserts.

Verification
REQ-038 Single CPU write: CPU_REQ=1, CPU_ADDR=100, CPU_DATA=16'hABCD -> one cycle with CPU_ACK=1, MW_VGA_ON=1, WADDR_VGA=100, DATA_IN_VGA=16'hABCD; exactly one write.
REQ-039 Tie from reset: CPU_REQ and KB_REQ both held high -> grants alternate CPU, KB, CPU, KB; KB_CURSOR steps 0, 1, 2.
REQ-040 Clear with MEM_SIZE=8: pulse CLR_REQ, KB_REQ held -> BUSY high 8 cycles, writes 0 to addresses 0..7, then KB_ACK with WADDR_VGA=0.
REQ-041 Cursor wrap with MEM_SIZE=8: 9 keyboard writes -> addresses 0..7 then 0; KB_CURSOR=1 at the end.
REQ-042 Bad address: CPU_ADDR=20000 at default MEM_SIZE -> CPU_ACK=1, MW_VGA_ON=0, ADDR_ERR=1 and still 1 after 10 idle cycles.
REQ-043 Reset mid-clear: RST on cycle 3 of a clear -> BUSY=0 and MW_VGA_ON=0 at once; no writes after RST deasserts.
